mem_bus_responder: RTL and testbench

- Responder end of the core's instruction and data buses: generates `instr_ready` and `data_ready`, which the pipeline uses to hold fetch/mem stalls.
- Arbitrates the two initiator ports onto one external single-port SRAM with fixed 1-cycle read latency, plus programmable wait states.
- Sits between the core and the on-chip RAM in the SoC top.

---
 rtl/mem_bus_pkg.sv | 11 +
 rtl/mem_bus_arbiter.sv | 29 ++
 rtl/mem_bus_responder.sv | 166 ++++++++++++++++
 tb/tb_mem_bus_responder.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types for the instruction/data bus responder.
// Round-robin arbitration is enabled by defining MEM_BUS_ROUND_ROBIN_EN.
package mem_bus_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  typedef enum logic [1:0] {NONE, INSTR, DATA} grant_t;

  localparam int unsigned MAX_WAIT_STATES = 15;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Combinational grant select between the fetch and load/store initiators.
// With MEM_BUS_ROUND_ROBIN_EN defined, ties go to the port not served last.
module mem_bus_arbiter
  import mem_bus_pkg::*;
(
  input  logic   instr_req,
  input  logic   data_req,
`ifdef MEM_BUS_ROUND_ROBIN_EN
  input  grant_t last_grant,
`endif
  output grant_t grant
);

  always_comb begin
    grant = NONE;
    if (data_req && instr_req) begin
`ifdef MEM_BUS_ROUND_ROBIN_EN
      grant = (last_grant == DATA) ? INSTR : DATA;
`else
      grant = DATA;
`endif
    end else if (data_req) begin
      grant = DATA;
    end else if (instr_req) begin
      grant = INSTR;
    end
  end

endmodule

// File: rtl/mem_bus_responder.sv
// Responder for the core's instruction and data buses onto one single-port SRAM.
// Optional round-robin tie-break between ports: define MEM_BUS_ROUND_ROBIN_EN.
module mem_bus_responder
  import mem_bus_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           instr_address_in,
  input  logic                  instr_read_in,
  output logic [31:0]           instr_read_value_out,
  output logic                  instr_ready_out,
  input  logic [31:0]           data_address_in,
  input  logic                  data_read_in,
  input  logic                  data_write_in,
  input  logic [3:0]            data_write_mask_in,
  input  logic [31:0]           data_write_value_in,
  output logic [31:0]           data_read_value_out,
  output logic                  data_ready_out,
  output logic [ADDR_WIDTH-1:0] mem_address_out,
  output logic                  mem_read_out,
  output logic                  mem_write_out,
  output logic [3:0]            mem_write_mask_out,
  output logic [31:0]           mem_write_value_out,
  input  logic [31:0]           mem_read_value_in
);

  localparam int unsigned CntW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(WAIT_STATES);

  state_t                state_q, state_d;
  grant_t                grant_q, grant_d, arb_grant;
  logic                  write_q, write_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [3:0]            mask_q, mask_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           hold_q, hold_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [31:0]           rd_value;
  logic                  data_req;
  logic                  unused_addr_bits;

  assign data_req = data_read_in | data_write_in;
  // Byte offset and bits above the SRAM range are dropped, so addresses wrap.
  assign unused_addr_bits = ^{instr_address_in[31:ADDR_WIDTH+2], instr_address_in[1:0],
                              data_address_in[31:ADDR_WIDTH+2], data_address_in[1:0]};
  assign rd_value = (WAIT_STATES == 0) ? mem_read_value_in : hold_q;

`ifdef MEM_BUS_ROUND_ROBIN_EN
  grant_t last_grant_q, last_grant_d;

  assign last_grant_d = (state_q == IDLE && arb_grant != NONE) ? arb_grant : last_grant_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_grant_q <= INSTR;
    else       last_grant_q <= last_grant_d;
  end
`endif

  mem_bus_arbiter u_arbiter (
    .instr_req  (instr_read_in),
    .data_req   (data_req),
`ifdef MEM_BUS_ROUND_ROBIN_EN
    .last_grant (last_grant_q),
`endif
    .grant      (arb_grant)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= NONE;
      write_q <= 1'b0;
      addr_q  <= '0;
      mask_q  <= '0;
      wdata_q <= '0;
      hold_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      mask_q  <= mask_d;
      wdata_q <= wdata_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    write_d = write_q;
    addr_d  = addr_q;
    mask_d  = mask_q;
    wdata_d = wdata_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (arb_grant != NONE) begin
          state_d = ISSUE;
          grant_d = arb_grant;
          // Read and write together count as a write.
          write_d = (arb_grant == DATA) && data_write_in;
          addr_d  = (arb_grant == DATA) ? data_address_in[ADDR_WIDTH+1:2]
                                        : instr_address_in[ADDR_WIDTH+1:2];
          mask_d  = write_d ? data_write_mask_in : 4'h0;
          wdata_d = write_d ? data_write_value_in : 32'h0;
        end
      end
      ISSUE: begin
        cnt_d   = CntLoad;
        state_d = (WAIT_STATES > 0) ? WAIT : RESP;
      end
      WAIT: begin
        // First WAIT cycle is when the SRAM's registered read data is valid.
        if (cnt_q == CntLoad) hold_d = mem_read_value_in;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CntW'(1)) state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
        grant_d = NONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_address_out      = '0;
    mem_read_out         = 1'b0;
    mem_write_out        = 1'b0;
    mem_write_mask_out   = 4'h0;
    mem_write_value_out  = 32'h0;
    instr_ready_out      = 1'b0;
    instr_read_value_out = 32'h0;
    data_ready_out       = 1'b0;
    data_read_value_out  = 32'h0;
    unique case (state_q)
      ISSUE: begin
        mem_address_out     = addr_q;
        mem_read_out        = !write_q;
        mem_write_out       = write_q;
        mem_write_mask_out  = mask_q;
        mem_write_value_out = wdata_q;
      end
      RESP: begin
        // A withdrawn request gets no ready even though the access completed.
        if (grant_q == INSTR && instr_read_in) begin
          instr_ready_out      = 1'b1;
          instr_read_value_out = rd_value;
        end
        if (grant_q == DATA && data_req) begin
          data_ready_out = 1'b1;
          if (!write_q) data_read_value_out = rd_value;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench: four responders (WAIT_STATES 0, 2, 3, 15) each backed by a byte-masked SRAM.
// Tie-break expectations follow MEM_BUS_ROUND_ROBIN_EN when it is defined.
module tb_mem_bus_responder;

  localparam int NI = 4;

  function automatic int unsigned ws_of(input int g);
    case (g)
      0:       return 0;
      1:       return 2;
      2:       return 3;
      default: return 15;
    endcase
  endfunction

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] i_addr [NI];
  logic        i_rd   [NI];
  logic [31:0] i_rval [NI];
  logic        i_rdy  [NI];
  logic [31:0] d_addr [NI];
  logic        d_rd   [NI];
  logic        d_wr   [NI];
  logic [3:0]  d_mask [NI];
  logic [31:0] d_wval [NI];
  logic [31:0] d_rval [NI];
  logic        d_rdy  [NI];
  logic [11:0] m_addr [NI];
  logic        m_rd   [NI];
  logic        m_wr   [NI];
  logic [3:0]  m_mask [NI];
  logic [31:0] m_wval [NI];
  logic [31:0] m_rdata[NI];
  logic [31:0] m_rin  [NI];
  logic        ovr_en [NI];
  logic [31:0] ovr_val[NI];
  logic [31:0] mem    [NI][4096];

  int tests = 0;
  int fails = 0;

  // Results of the last run_access call.
  int          r_rdy_cyc, r_rdy_cnt, r_op_cyc, r_op_cnt, r_stray;
  logic        r_op_rd, r_op_wr;
  logic [11:0] r_op_addr;
  logic [3:0]  r_op_mask;
  logic [31:0] r_op_val, r_rval;

  // Results of the last run_both call (port code 1 = instr, 2 = data).
  int          b_n, b_both;
  int          b_cyc  [4];
  int          b_port [4];
  logic [31:0] b_val  [4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    assign m_rin[g] = ovr_en[g] ? ovr_val[g] : m_rdata[g];

    mem_bus_responder #(
      .ADDR_WIDTH  (12),
      .WAIT_STATES (ws_of(g))
    ) u_dut (
      .clk                  (clk),
      .reset                (reset),
      .instr_address_in     (i_addr[g]),
      .instr_read_in        (i_rd[g]),
      .instr_read_value_out (i_rval[g]),
      .instr_ready_out      (i_rdy[g]),
      .data_address_in      (d_addr[g]),
      .data_read_in         (d_rd[g]),
      .data_write_in        (d_wr[g]),
      .data_write_mask_in   (d_mask[g]),
      .data_write_value_in  (d_wval[g]),
      .data_read_value_out  (d_rval[g]),
      .data_ready_out       (d_rdy[g]),
      .mem_address_out      (m_addr[g]),
      .mem_read_out         (m_rd[g]),
      .mem_write_out        (m_wr[g]),
      .mem_write_mask_out   (m_mask[g]),
      .mem_write_value_out  (m_wval[g]),
      .mem_read_value_in    (m_rin[g])
    );
  end

  // SRAM model: byte-masked write, registered read with one cycle latency.
  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (m_wr[k]) begin
        for (int b = 0; b < 4; b++) begin
          if (m_mask[k][b]) mem[k][m_addr[k]][8*b +: 8] <= m_wval[k][8*b +: 8];
        end
      end
      if (m_rd[k]) m_rdata[k] <= mem[k][m_addr[k]];
    end
  end

  // Drives one request at a negedge (cycle N) and records what happens over the next 24 cycles.
  task automatic run_access(input int k, input bit instr, input bit rd, input bit wr,
                            input logic [31:0] addr, input logic [3:0] mask,
                            input logic [31:0] wval, input int drop_at, input int ovr_at);
    logic        rdy;
    logic [31:0] v;
    r_rdy_cyc = -1; r_rdy_cnt = 0; r_op_cyc = -1; r_op_cnt = 0; r_stray = 0;
    r_op_rd = 1'b0; r_op_wr = 1'b0; r_op_addr = '0; r_op_mask = '0; r_op_val = '0; r_rval = '0;
    @(negedge clk);
    if (instr) begin
      i_addr[k] = addr; i_rd[k] = 1'b1;
    end else begin
      d_addr[k] = addr; d_rd[k] = rd; d_wr[k] = wr; d_mask[k] = mask; d_wval[k] = wval;
    end
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      rdy = instr ? i_rdy[k] : d_rdy[k];
      v   = instr ? i_rval[k] : d_rval[k];
      if (instr ? d_rdy[k] : i_rdy[k]) r_stray++;
      if (!rdy && v != 32'h0) r_stray++;
      if (rdy) begin
        r_rdy_cnt++;
        if (r_rdy_cyc < 0) begin r_rdy_cyc = c; r_rval = v; end
      end
      if (m_rd[k] || m_wr[k]) begin
        r_op_cnt++;
        if (r_op_cyc < 0) begin
          r_op_cyc = c; r_op_rd = m_rd[k]; r_op_wr = m_wr[k];
          r_op_addr = m_addr[k]; r_op_mask = m_mask[k]; r_op_val = m_wval[k];
        end
      end
      if (c == ovr_at) begin ovr_en[k] = 1'b1; ovr_val[k] = 32'h1111_2222; end
      if (rdy || c == drop_at) begin
        if (instr) i_rd[k] = 1'b0;
        else begin d_rd[k] = 1'b0; d_wr[k] = 1'b0; end
      end
    end
    ovr_en[k] = 1'b0;
  endtask

  // Both ports read (instr 0x40, data 0x80) from the same cycle; hold=1 keeps both asserted.
  task automatic run_both(input int k, input bit hold, input int ncyc);
    b_n = 0; b_both = 0;
    @(negedge clk);
    i_addr[k] = 32'h40; i_rd[k] = 1'b1;
    d_addr[k] = 32'h80; d_rd[k] = 1'b1; d_wr[k] = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (i_rdy[k] && d_rdy[k]) b_both++;
      if (i_rdy[k] || d_rdy[k]) begin
        if (b_n < 4) begin
          b_cyc[b_n]  = c;
          b_port[b_n] = d_rdy[k] ? 2 : 1;
          b_val[b_n]  = d_rdy[k] ? d_rval[k] : i_rval[k];
        end
        b_n++;
      end
      if (!hold) begin
        if (i_rdy[k]) i_rd[k] = 1'b0;
        if (d_rdy[k]) d_rd[k] = 1'b0;
      end
    end
    i_rd[k] = 1'b0; d_rd[k] = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int k = 0; k < NI; k++) begin
      i_addr[k] = 32'h40; i_rd[k] = 1'b1; d_addr[k] = 32'h8; d_rd[k] = 1'b1; d_wr[k] = 1'b1;
      d_mask[k] = 4'hF; d_wval[k] = 32'hFFFF_FFFF; ovr_en[k] = 1'b0; ovr_val[k] = '0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      tests++;
      if ({i_rdy[k], d_rdy[k], m_rd[k], m_wr[k], m_mask[k]} !== 8'h0 || m_addr[k] !== 12'h0
          || m_wval[k] !== 32'h0 || i_rval[k] !== 32'h0 || d_rval[k] !== 32'h0) begin
        fails++;
        $display("FAIL reset_outputs[%0d]: rdy=%b/%b rd=%b wr=%b addr=%h, all required 0",
                 k, i_rdy[k], d_rdy[k], m_rd[k], m_wr[k], m_addr[k]);
      end
    end
    for (int k = 0; k < NI; k++) begin
      i_rd[k] = 1'b0; d_rd[k] = 1'b0; d_wr[k] = 1'b0; d_mask[k] = 4'h0; d_wval[k] = '0;
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_data_write();
    run_access(0, 1'b0, 1'b0, 1'b1, 32'h40, 4'hF, 32'hDEAD_BEEF, 0, 0);
    tests++;
    if (r_op_cyc !== 1 || r_op_cnt !== 1 || r_op_wr !== 1'b1 || r_op_rd !== 1'b0
        || r_op_addr !== 12'h010 || r_op_mask !== 4'hF || r_op_val !== 32'hDEAD_BEEF) begin
      fails++;
      $display("FAIL wr_issue: cyc=%0d cnt=%0d wr=%b rd=%b addr=%h mask=%h val=%h, want 1 1 1 0 010 f deadbeef",
               r_op_cyc, r_op_cnt, r_op_wr, r_op_rd, r_op_addr, r_op_mask, r_op_val);
    end
    tests++;
    if (r_rdy_cyc !== 2 || r_rdy_cnt !== 1 || r_rval !== 32'h0 || r_stray !== 0) begin
      fails++;
      $display("FAIL wr_ready: cyc=%0d cnt=%0d val=%h stray=%0d, want 2 1 0 0",
               r_rdy_cyc, r_rdy_cnt, r_rval, r_stray);
    end
    run_access(0, 1'b0, 1'b0, 1'b1, 32'h8, 4'hF, 32'hAABB_CCDD, 0, 0);
    // Read and write both high: must be a write with mask 3 at word 2.
    run_access(0, 1'b0, 1'b1, 1'b1, 32'h8, 4'b0011, 32'h0000_1234, 0, 0);
    tests++;
    if (r_op_cyc !== 1 || r_op_cnt !== 1 || r_op_wr !== 1'b1 || r_op_rd !== 1'b0
        || r_op_addr !== 12'h002 || r_op_mask !== 4'h3 || r_op_val !== 32'h0000_1234) begin
      fails++;
      $display("FAIL wr_masked_issue: cyc=%0d cnt=%0d wr=%b rd=%b addr=%h mask=%h val=%h, want 1 1 1 0 002 3 00001234",
               r_op_cyc, r_op_cnt, r_op_wr, r_op_rd, r_op_addr, r_op_mask, r_op_val);
    end
    tests++;
    if (r_rdy_cyc !== 2 || r_rdy_cnt !== 1 || r_rval !== 32'h0) begin
      fails++;
      $display("FAIL wr_masked_ready: cyc=%0d cnt=%0d val=%h, want 2 1 0", r_rdy_cyc, r_rdy_cnt, r_rval);
    end
  endtask

  task automatic test_instr_read();
    run_access(0, 1'b1, 1'b1, 1'b0, 32'h40, 4'h0, 32'h0, 0, 0);
    tests++;
    if (r_op_cyc !== 1 || r_op_cnt !== 1 || r_op_rd !== 1'b1 || r_op_wr !== 1'b0
        || r_op_addr !== 12'h010) begin
      fails++;
      $display("FAIL rd_issue: cyc=%0d cnt=%0d rd=%b wr=%b addr=%h, want 1 1 1 0 010",
               r_op_cyc, r_op_cnt, r_op_rd, r_op_wr, r_op_addr);
    end
    tests++;
    if (r_rdy_cyc !== 2 || r_rdy_cnt !== 1 || r_rval !== 32'hDEAD_BEEF || r_stray !== 0) begin
      fails++;
      $display("FAIL rd_ready: cyc=%0d cnt=%0d val=%h stray=%0d, want 2 1 deadbeef 0",
               r_rdy_cyc, r_rdy_cnt, r_rval, r_stray);
    end
    // Bits above the SRAM range and the byte offset are ignored.
    run_access(0, 1'b1, 1'b1, 1'b0, 32'hFFFF_C043, 4'h0, 32'h0, 0, 0);
    tests++;
    if (r_op_addr !== 12'h010 || r_rval !== 32'hDEAD_BEEF) begin
      fails++;
      $display("FAIL rd_wrap: addr=%h val=%h, want 010 deadbeef", r_op_addr, r_rval);
    end
    run_access(0, 1'b0, 1'b1, 1'b0, 32'h8, 4'h0, 32'h0, 0, 0);
    tests++;
    if (r_rdy_cyc !== 2 || r_rval !== 32'hAABB_1234) begin
      fails++;
      $display("FAIL load_masked_word: cyc=%0d val=%h, want 2 aabb1234", r_rdy_cyc, r_rval);
    end
  endtask

  task automatic test_priority();
    run_access(1, 1'b0, 1'b0, 1'b1, 32'h40, 4'hF, 32'hDEAD_BEEF, 0, 0);
    tests++;
    if (r_rdy_cyc !== 4) begin
      fails++;
      $display("FAIL ws2_write_ready: cyc=%0d, want 4", r_rdy_cyc);
    end
    run_access(1, 1'b0, 1'b0, 1'b1, 32'h80, 4'hF, 32'h0BAD_F00D, 0, 0);
    run_both(1, 1'b0, 12);
`ifdef MEM_BUS_ROUND_ROBIN_EN
    // Last grant was DATA (the preload writes), so the tie goes to instr.
    tests++;
    if (b_n !== 2 || b_both !== 0 || b_cyc[0] !== 4 || b_port[0] !== 1 || b_val[0] !== 32'hDEAD_BEEF
        || b_cyc[1] !== 9 || b_port[1] !== 2 || b_val[1] !== 32'h0BAD_F00D) begin
      fails++;
      $display("FAIL tie_order: n=%0d both=%0d c0=%0d p0=%0d v0=%h c1=%0d p1=%0d v1=%h, want 2 0 4 1 deadbeef 9 2 0badf00d",
               b_n, b_both, b_cyc[0], b_port[0], b_val[0], b_cyc[1], b_port[1], b_val[1]);
    end
`else
    tests++;
    if (b_n !== 2 || b_both !== 0 || b_cyc[0] !== 4 || b_port[0] !== 2 || b_val[0] !== 32'h0BAD_F00D
        || b_cyc[1] !== 9 || b_port[1] !== 1 || b_val[1] !== 32'hDEAD_BEEF) begin
      fails++;
      $display("FAIL tie_order: n=%0d both=%0d c0=%0d p0=%0d v0=%h c1=%0d p1=%0d v1=%h, want 2 0 4 2 0badf00d 9 1 deadbeef",
               b_n, b_both, b_cyc[0], b_port[0], b_val[0], b_cyc[1], b_port[1], b_val[1]);
    end
`endif
  endtask

  task automatic test_hold_both();
    int want [3];
    run_both(1, 1'b1, 15);
`ifdef MEM_BUS_ROUND_ROBIN_EN
    want = '{1, 2, 1};
`else
    want = '{2, 2, 2};
`endif
    tests++;
    if (b_n !== 3 || b_both !== 0 || b_cyc[0] !== 4 || b_cyc[1] !== 9 || b_cyc[2] !== 14
        || b_port[0] !== want[0] || b_port[1] !== want[1] || b_port[2] !== want[2]) begin
      fails++;
      $display("FAIL held_grants: n=%0d both=%0d cyc=%0d,%0d,%0d port=%0d,%0d,%0d, want 3 0 4,9,14 %0d,%0d,%0d",
               b_n, b_both, b_cyc[0], b_cyc[1], b_cyc[2], b_port[0], b_port[1], b_port[2],
               want[0], want[1], want[2]);
    end
  endtask

  task automatic test_withdraw();
    run_access(2, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 2, 0);
    tests++;
    if (r_op_cyc !== 1 || r_op_cnt !== 1 || r_op_rd !== 1'b1 || r_rdy_cnt !== 0 || r_stray !== 0) begin
      fails++;
      $display("FAIL withdraw: op_cyc=%0d op_cnt=%0d rd=%b ready_cnt=%0d stray=%0d, want 1 1 1 0 0",
               r_op_cyc, r_op_cnt, r_op_rd, r_rdy_cnt, r_stray);
    end
    run_access(2, 1'b0, 1'b0, 1'b1, 32'h10, 4'hF, 32'h55AA_55AA, 0, 0);
    tests++;
    if (r_op_cyc !== 1 || r_rdy_cyc !== 5 || r_rdy_cnt !== 1) begin
      fails++;
      $display("FAIL after_withdraw_write: op=%0d ready=%0d cnt=%0d, want 1 5 1",
               r_op_cyc, r_rdy_cyc, r_rdy_cnt);
    end
    run_access(2, 1'b0, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 0, 0);
    tests++;
    if (r_rdy_cyc !== 5 || r_rval !== 32'h55AA_55AA) begin
      fails++;
      $display("FAIL ws3_load: cyc=%0d val=%h, want 5 55aa55aa", r_rdy_cyc, r_rval);
    end
  endtask

  task automatic test_long_wait();
    run_access(3, 1'b0, 1'b0, 1'b1, 32'h20, 4'hF, 32'hCAFE_F00D, 0, 0);
    tests++;
    if (r_rdy_cyc !== 17 || r_rdy_cnt !== 1) begin
      fails++;
      $display("FAIL ws15_write_ready: cyc=%0d cnt=%0d, want 17 1", r_rdy_cyc, r_rdy_cnt);
    end
    // SRAM data is overridden from cycle N+3 on; the held value must be the N+2 one.
    run_access(3, 1'b0, 1'b1, 1'b0, 32'h20, 4'h0, 32'h0, 0, 3);
    tests++;
    if (r_rdy_cyc !== 17 || r_rdy_cnt !== 1 || r_rval !== 32'hCAFE_F00D || r_stray !== 0) begin
      fails++;
      $display("FAIL ws15_load: cyc=%0d cnt=%0d val=%h stray=%0d, want 17 1 cafef00d 0",
               r_rdy_cyc, r_rdy_cnt, r_rval, r_stray);
    end
  endtask

  task automatic test_reset_mid();
    logic bad_rdy;
    @(negedge clk);
    d_addr[0] = 32'h100; d_wr[0] = 1'b1; d_mask[0] = 4'hF; d_wval[0] = 32'h77;
    @(negedge clk);
    tests++;
    if (m_wr[0] !== 1'b1) begin
      fails++;
      $display("FAIL mid_issue_write: mem_write=%b, want 1", m_wr[0]);
    end
    #2 reset = 1'b1;
    #1;
    tests++;
    if (m_wr[0] !== 1'b0 || m_addr[0] !== 12'h0 || m_mask[0] !== 4'h0) begin
      fails++;
      $display("FAIL async_reset_drop: wr=%b addr=%h mask=%h, want 0 000 0", m_wr[0], m_addr[0], m_mask[0]);
    end
    bad_rdy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int k = 0; k < NI; k++) bad_rdy = bad_rdy | i_rdy[k] | d_rdy[k];
    end
    d_wr[0] = 1'b0;
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      for (int k = 0; k < NI; k++) bad_rdy = bad_rdy | i_rdy[k] | d_rdy[k];
    end
    tests++;
    if (bad_rdy !== 1'b0) begin
      fails++;
      $display("FAIL reset_ready: saw ready=%b, want 0", bad_rdy);
    end
    run_access(0, 1'b1, 1'b1, 1'b0, 32'h40, 4'h0, 32'h0, 0, 0);
    tests++;
    if (r_rdy_cyc !== 2 || r_rval !== 32'hDEAD_BEEF) begin
      fails++;
      $display("FAIL post_reset_read: cyc=%0d val=%h, want 2 deadbeef", r_rdy_cyc, r_rval);
    end
  endtask

  initial begin
    test_reset();
    test_data_write();
    test_instr_read();
    test_priority();
    test_hold_both();
    test_withdraw();
    test_long_wait();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete within time limit");
    $fatal(1, "timeout");
  end

endmodule
